// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the store path toward data memory.
//   size_e         : store size encoding carried with each request
//   BE_ALL         : byte-enable pattern for a full-word store
//   store_entry_t  : one buffered store {word address, lane data, byte enables
//                    [, truncation flag]}
//   narrow_trunc() : true when a value is not the sign extension of its
//                    narrowed field (NARROW_CHECK_EN builds only)
// Optional feature macro: NARROW_CHECK_EN (adds the truncation flag).
// ----------------------------------------------------------------------------
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
`ifdef NARROW_CHECK_EN
        logic        trunc;
`endif
    } store_entry_t;

`ifdef NARROW_CHECK_EN
    // Upper bits must all equal the sign bit of the narrowed field.
    function automatic logic narrow_trunc(input logic [31:0] d, input size_e sz);
        logic res;
        case (sz)
            SZ_BYTE: res = (d[31:8] != {24{d[7]}});
            SZ_HALF: res = (d[31:16] != {16{d[15]}});
            default: res = 1'b0;
        endcase
        return res;
    endfunction
`endif

endpackage

// File: rtl/store_lane_pack.sv
// ----------------------------------------------------------------------------
// store_lane_pack
// Combinational narrowing of one store request: replicates the narrowed
// field into every lane it could occupy and selects the addressed lanes.
// Ports:
//   addr_lo    in  2   low address bits (byte offset within the word)
//   data       in  32  full register value
//   size       in  2   size_e encoding
//   wdata      out 32  lane-replicated write data
//   be         out 4   byte enables (bit i = byte lane i)
//   misaligned out 1   request cannot be issued as a single aligned access
//   trunc      out 1   value does not fit the narrowed size (NARROW_CHECK_EN)
// ----------------------------------------------------------------------------
module store_lane_pack
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [31:0] wdata,
    output logic [3:0]  be,
`ifdef NARROW_CHECK_EN
    output logic        trunc,
`endif
    output logic        misaligned
);

    size_e sz_s;
    assign sz_s = size_e'(size);

`ifdef NARROW_CHECK_EN
    assign trunc = narrow_trunc(data, sz_s);
`endif

    // Lane replication, byte-enable selection and alignment check.
    always_comb begin
        wdata      = 32'h0000_0000;
        be         = 4'b0000;
        misaligned = 1'b0;
        case (sz_s)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata      = {2{data[15:0]}};
                misaligned = addr_lo[0];
                if (addr_lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
            end
            SZ_WORD: begin
                wdata      = data;
                be         = BE_ALL;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                // Reserved size: dropped like a misaligned store.
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// ----------------------------------------------------------------------------
// store_narrow_unit
// Narrows register values for sb/sh/sw, buffers the resulting memory writes
// in a DEPTH-entry FIFO and presents the oldest one to data memory.
// Misaligned or reserved-size requests are consumed but dropped, flagged by a
// one-cycle misalign_err pulse.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready       request handshake
//   in_addr, in_data, in_size  request payload
//   out_valid/out_ready     memory-side handshake for the FIFO head
//   out_addr, out_wdata, out_be  head entry (word address, lane data, enables)
//   out_trunc               head entry truncation flag (NARROW_CHECK_EN only)
//   misalign_err            pulse one cycle after a dropped request
//   count                   FIFO occupancy
// Optional feature macro: NARROW_CHECK_EN.
// ----------------------------------------------------------------------------
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_size,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_wdata,
    output logic [3:0]       out_be,
`ifdef NARROW_CHECK_EN
    output logic             out_trunc,
`endif
    output logic             misalign_err,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    store_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               misalign_r;

    logic [31:0]        pack_wdata_s;
    logic [3:0]         pack_be_s;
    logic               misaligned_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    store_entry_t       entry_s;

    store_lane_pack u_pack (
        .addr_lo    (in_addr[1:0]),
        .data       (in_data),
        .size       (in_size),
        .wdata      (pack_wdata_s),
        .be         (pack_be_s),
`ifdef NARROW_CHECK_EN
        .trunc      (entry_s.trunc),
`endif
        .misaligned (misaligned_s)
    );

    assign entry_s.addr  = in_addr[31:2];
    assign entry_s.wdata = pack_wdata_s;
    assign entry_s.be    = pack_be_s;

    // No pop-bypass: a full FIFO refuses requests even when the head is leaving.
    assign in_ready  = !reset && (count_r < CNT_FULL);
    assign out_valid = (count_r != {CNT_W{1'b0}});
    assign accept_s  = in_valid && in_ready;
    assign push_s    = accept_s && !misaligned_s;
    assign pop_s     = out_valid && out_ready;

    // FIFO storage; cleared on reset so the idle outputs read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers (wrap naturally, DEPTH is a power of two), occupancy and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= accept_s && misaligned_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign out_addr     = {mem_r[rd_ptr_r].addr, 2'b00};
    assign out_wdata    = mem_r[rd_ptr_r].wdata;
    assign out_be       = mem_r[rd_ptr_r].be;
`ifdef NARROW_CHECK_EN
    assign out_trunc    = mem_r[rd_ptr_r].trunc;
`endif
    assign misalign_err = misalign_r;
    assign count        = count_r;

endmodule

// File: tb/tb_store_narrow_unit.sv
// ----------------------------------------------------------------------------
// tb_store_narrow_unit
// Directed scenarios followed by random traffic. Expected memory writes are
// derived from the store rules with plain arithmetic and queued; a negedge
// monitor compares the DUT head, occupancy and error pulse against the queue.
// ----------------------------------------------------------------------------
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_size = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;
    logic        misalign_err;
    logic [2:0]  count;
`ifdef NARROW_CHECK_EN
    logic        out_trunc;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        trunc;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_entry;
    logic pend_push = 1'b0;
    logic pend_pop  = 1'b0;
    logic pend_err  = 1'b0;

    store_narrow_unit #(.DEPTH(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_size      (in_size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_wdata    (out_wdata),
        .out_be       (out_be),
`ifdef NARROW_CHECK_EN
        .out_trunc    (out_trunc),
`endif
        .misalign_err (misalign_err),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model of one request: returns the memory write and whether it is dropped.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] s, output logic bad);
        exp_t e;
        int off;
        off     = a % 4;
        e.addr  = a - off;
        e.wdata = 32'h0;
        e.be    = 4'h0;
        e.trunc = 1'b0;
        bad     = 1'b0;
        if (s == 2'd0) begin
            e.wdata = {24'h0, d[7:0]} * 32'h0101_0101;
            e.be    = 4'(1 << off);
            e.trunc = (32'($signed(d[7:0])) != d);
        end else if (s == 2'd1) begin
            e.wdata = {16'h0, d[15:0]} * 32'h0001_0001;
            e.be    = (off >= 2) ? 4'hC : 4'h3;
            e.trunc = (32'($signed(d[15:0])) != d);
            bad     = (off % 2) != 0;
        end else if (s == 2'd2) begin
            e.wdata = d;
            e.be    = 4'hF;
            bad     = (off != 0);
        end else begin
            bad = 1'b1;
        end
        return e;
    endfunction

    // Monitor: apply the previous edge's handshakes to the model, compare, then predict the next edge.
    always @(negedge clk) begin
        logic bad;
        exp_t e;
        if (reset) begin
            exp_q.delete();
            pend_push = 1'b0;
            pend_pop  = 1'b0;
            pend_err  = 1'b0;
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_misalign", 32'(misalign_err), 32'd0);
            chk("rst_out_addr", out_addr, 32'd0);
            chk("rst_out_wdata", out_wdata, 32'd0);
            chk("rst_out_be", 32'(out_be), 32'd0);
        end else begin
            if (pend_pop) void'(exp_q.pop_front());
            if (pend_push) exp_q.push_back(pend_entry);
            chk("misalign_err", 32'(misalign_err), 32'(pend_err));
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 4));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_addr", out_addr, exp_q[0].addr);
                chk("out_wdata", out_wdata, exp_q[0].wdata);
                chk("out_be", 32'(out_be), 32'(exp_q[0].be));
`ifdef NARROW_CHECK_EN
                chk("out_trunc", 32'(out_trunc), 32'(exp_q[0].trunc));
`endif
            end
            pend_pop  = (exp_q.size() != 0) && out_ready;
            pend_push = 1'b0;
            pend_err  = 1'b0;
            if (in_valid && (exp_q.size() < 4)) begin
                e = model(in_addr, in_data, in_size, bad);
                if (bad) begin
                    pend_err = 1'b1;
                end else begin
                    pend_push  = 1'b1;
                    pend_entry = e;
                end
            end
        end
    end

    // Drive one request and hold it until the handshake completes (bounded).
    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        logic done;
        done = 1'b0;
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_size  = s;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL push_timeout actual=no_accept expected=accept t=%0t", $time);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk) #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] cnt_before;
        logic        done;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: byte store into lane 3
        push_one(32'h0000_1003, 32'hFFFF_FFA5, 2'b00);
        @(negedge clk);
        chk("t1_addr", out_addr, 32'h0000_1000);
        chk("t1_wdata", out_wdata, 32'hA5A5_A5A5);
        chk("t1_be", 32'(out_be), 32'h8);
        drain();

        // 2: half store into the upper half
        push_one(32'h0000_2002, 32'h0000_1234, 2'b01);
        @(negedge clk);
        chk("t2_addr", out_addr, 32'h0000_2000);
        chk("t2_wdata", out_wdata, 32'h1234_1234);
        chk("t2_be", 32'(out_be), 32'hC);
        drain();
`ifdef NARROW_CHECK_EN
        push_one(32'h0000_2000, 32'h0001_8000, 2'b01);
        @(negedge clk);
        chk("t2_trunc", 32'(out_trunc), 32'd1);
        drain();
`endif

        // 3: misaligned word and reserved size are dropped
        push_one(32'h0000_4000, 32'h1111_2222, 2'b10);
        @(negedge clk);
        cnt_before = 32'(count);
        push_one(32'h0000_3001, 32'hDEAD_BEEF, 2'b10);
        @(negedge clk);
        chk("t3_err", 32'(misalign_err), 32'd1);
        chk("t3_count", 32'(count), cnt_before);
        @(negedge clk);
        chk("t3_err_pulse", 32'(misalign_err), 32'd0);
        push_one(32'h0000_3000, 32'hDEAD_BEEF, 2'b11);
        @(negedge clk);
        chk("t3_rsvd_err", 32'(misalign_err), 32'd1);
        chk("t3_rsvd_count", 32'(count), cnt_before);
        drain();

        // 4: fill to full, fifth push waits for space
        for (int i = 0; i < 4; i++) push_one(32'h0000_5000 + 32'(4 * i), $urandom, 2'b10);
        @(negedge clk);
        chk("t4_full_count", 32'(count), 32'd4);
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_addr  = 32'h0000_5010;
        in_data  = 32'h5555_AAAA;
        in_size  = 2'b10;
        repeat (3) begin
            @(negedge clk);
            chk("t4_blocked", 32'(in_ready), 32'd0);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                break;
            end
        end
        chk("t4_fifth_accept", 32'(done), 32'd1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        drain();

        // 5: steady push+pop at count 2 across pointer wrap
        push_one(32'h0000_6000, $urandom, 2'b10);
        push_one(32'h0000_6004, $urandom, 2'b10);
        @(posedge clk) #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_size   = 2'b00;
        in_addr   = 32'h0000_7000;
        in_data   = $urandom;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t5_count", 32'(count), 32'd2);
            @(posedge clk) #1;
            in_addr = 32'h0000_7000 + 32'(i);
            in_data = $urandom;
            if (i == 8) in_valid = 1'b0;
        end
        drain();

        // 6: asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++) push_one(32'h0000_8000 + 32'(4 * i), $urandom, 2'b10);
        @(negedge clk);
        chk("t6_pre_count", 32'(count), 32'd3);
        @(posedge clk) #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        @(posedge clk) #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_stale", 32'(out_valid), 32'd0);
        end

        // Random traffic with bursts of back-pressure
        for (int i = 0; i < 600; i++) begin
            @(posedge clk) #1;
            in_valid  = ($urandom % 3) != 0;
            in_addr   = $urandom;
            in_data   = ($urandom % 2) ? $urandom : 32'($signed(16'($urandom)));
            in_size   = 2'($urandom % 4);
            if (in_size == 2'b10 && ($urandom % 2)) in_addr[1:0] = 2'b00;
            if (in_size == 2'b01 && ($urandom % 2)) in_addr[0] = 1'b0;
            out_ready = ((i / 40) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        drain();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
